alu_writeback_stage: RTL
========================

# alu_writeback_stage

Registered result/flag stage directly downstream of the 16-bit ALU. Captures each ALU result (S) and its CLFZN flags and holds the processor status register (PSR). Queues register-file writes in a 2-entry in-order buffer with a valid/ready handshake, and exposes the youngest pending value for operand forwarding. Feeds the stored carry back to the ALU for ADDC/ADDCI/ADDCU/ADDCUI.

## Interface
Parameters:
- DATA_W, 16, result/data width
- REG_AW, 4, register-file address width (16 registers)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  ALU result present this cycle
- in_ready  out  1  stage can accept this cycle
- in_result  in  DATA_W  ALU S output
- in_flags  in  5  ALU CLFZN output; bit4 C, bit3 L, bit2 F, bit1 Z, bit0 N
- in_flag_mask  in  5  PSR bits this op updates (1 = update)
- in_wr_en  in  1  result is written to the register file
- in_dest  in  REG_AW  destination register
- psr_we  in  1  direct PSR load (LPR-style)
- psr_wdata  in  5  value for direct PSR load
- psr  out  5  current PSR, registered
- carry_out  out  1  psr[4], ALU carry-in
- wb_valid  out  1  head entry valid
- wb_ready  in  1  register file accepts head
- wb_addr  out  REG_AW  head destination
- wb_data  out  DATA_W  head data
- lk_addr_a, lk_addr_b  in  REG_AW  forwarding lookup addresses
- lk_hit_a, lk_hit_b  out  1  a pending entry targets that address
- lk_data_a, lk_data_b  out  DATA_W  data of the youngest matching pending entry, 0 when no hit
- count  out  2  buffered entries (0..2)

## Operation
- Accept = in_valid & in_ready. in_ready = reset_n & (count != 2). It does not depend on wb_ready.
- On accept: psr <= (psr & ~in_flag_mask) | (in_flags & in_flag_mask). If in_wr_en = 1, push {in_dest, in_result} at the tail.
- An accepted op with in_wr_en = 0 (flags only) updates the PSR and does not occupy the buffer.
- psr_we in the same cycle as an accept: psr <= psr_wdata. The direct load wins all 5 bits and the ALU flag update is discarded. The buffer push still happens.
- Pop = wb_valid & wb_ready. wb_valid = (count != 0). wb_addr/wb_data always show the oldest entry.
- Push and pop in the same cycle: the count is unchanged and order is preserved. At count 1 the new entry becomes head on the next cycle. At count 2 no push is possible.
- Lookup is combinational over the valid entries.
  - If both entries match, the tail (younger) entry wins.
  - The incoming (not yet accepted) op is not searched.
- Buffer storage is two slots with head/tail pointers that wrap modulo 2.

## Timing
- Reset (reset_n low at an edge) sets: count 0, pointers 0, psr 0, wb_valid 0, wb_addr 0, wb_data 0, lk_hit_* 0, lk_data_* 0.
- in_ready is 0 during every cycle reset_n is low. Any in_valid, psr_we or wb_ready in those cycles is ignored.
- Reset mid-operation drops all buffered entries, with no writeback.
- Latency:
  - Accept at edge N makes wb_valid = 1 after edge N (in cycle N+1) if the buffer was empty.
  - psr and carry_out reflect the op after edge N.
  - Back-to-back ADDC therefore sees the previous op's carry.
- Throughput is one op per cycle while wb_ready stays 1.
- With wb_ready held 0, two ops fill the buffer and in_ready then drops. in_ready returns to 1 the cycle after the first pop.
- wb_addr/wb_data are stable while wb_valid = 1 and wb_ready = 0.

## Test plan
- Reset then idle:
  - Assert reset_n = 0 for 2 cycles with in_valid = 1, wb_ready = 1 -> psr = 0, count = 0, wb_valid = 0, in_ready = 0.
  - Release -> in_ready = 1.
- Single write:
  - Accept result 0x1234, dest 3, flags 5'b10010, mask 5'b11111.
  - Next cycle: wb_valid = 1, wb_addr = 3, wb_data = 0x1234, psr = 5'b10010, carry_out = 1.
  - Pop -> count = 0.
- Backpressure:
  - Hold wb_ready = 0 and offer dest 1 = 0xAAAA, then dest 2 = 0xBBBB, then a third op -> the third op is not accepted (in_ready = 0, count = 2).
  - Raise wb_ready -> 0xAAAA pops, then 0xBBBB pops, in order.
  - The third op is accepted on the cycle after the first pop.
- Forwarding:
  - Buffer holds dest 5 = 0x0001 (head) and dest 5 = 0x0002 (tail).
  - lk_addr_a = 5 -> lk_hit_a = 1, lk_data_a = 0x0002.
  - lk_addr_b = 6 -> lk_hit_b = 0, lk_data_b = 0.
- Flag mask and priority:
  - With psr = 5'b10000, accept a flags-only op with flags 5'b00010, mask 5'b00010 -> psr = 5'b10010 and count unchanged.
  - Same cycle as an accept with psr_we = 1, psr_wdata = 5'b00001 -> psr = 5'b00001.
- Simultaneous push/pop at count 1:
  - Head dest 7 = 0x00FF; pop and accept dest 8 = 0x0F0F in the same cycle -> count stays 1, next wb_addr = 8, wb_data = 0x0F0F.

Source files
------------

// File: rtl/alu_writeback_stage.sv
// Result/flag stage after the ALU: holds the PSR, feeds carry back to the ALU,
// and queues register-file writes in a 2-entry in-order buffer with forwarding lookup.
module alu_writeback_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [4:0]        in_flags,
  input  logic [4:0]        in_flag_mask,
  input  logic              in_wr_en,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              psr_we,
  input  logic [4:0]        psr_wdata,
  output logic [4:0]        psr,
  output logic              carry_out,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] lk_addr_a,
  input  logic [REG_AW-1:0] lk_addr_b,
  output logic              lk_hit_a,
  output logic              lk_hit_b,
  output logic [DATA_W-1:0] lk_data_a,
  output logic [DATA_W-1:0] lk_data_b,
  output logic [1:0]        count
);

  logic [REG_AW-1:0] addr_q [2];
  logic [DATA_W-1:0] data_q [2];
  logic              head_q;
  logic              tail_q;
  logic [1:0]        count_q;
  logic [4:0]        psr_q;

  logic accept;
  logic push;
  logic pop;
  logic yidx;
  logic old_v;
  logic young_v;
  logic old_hit_a, young_hit_a, old_hit_b, young_hit_b;

  assign in_ready  = reset_n && (count_q != 2'd2);
  assign accept    = in_valid && in_ready;
  assign push      = accept && in_wr_en;
  assign wb_valid  = (count_q != 2'd0);
  assign pop       = wb_valid && wb_ready;

  assign wb_addr   = addr_q[head_q];
  assign wb_data   = data_q[head_q];
  assign psr       = psr_q;
  assign carry_out = psr_q[4];
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q[0] <= '0;
      addr_q[1] <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= 2'd0;
      psr_q     <= 5'd0;
    end else begin
      // A direct load overrides the ALU flag merge on all five bits.
      if (psr_we)
        psr_q <= psr_wdata;
      else if (accept)
        psr_q <= (psr_q & ~in_flag_mask) | (in_flags & in_flag_mask);

      if (push) begin
        addr_q[tail_q] <= in_dest;
        data_q[tail_q] <= in_result;
        tail_q         <= ~tail_q;
      end
      if (pop)
        head_q <= ~head_q;

      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // With two entries the younger one sits in the slot after the head.
  assign yidx    = ~head_q;
  assign old_v   = (count_q != 2'd0);
  assign young_v = (count_q == 2'd2);

  assign old_hit_a   = old_v   && (addr_q[head_q] == lk_addr_a);
  assign young_hit_a = young_v && (addr_q[yidx]   == lk_addr_a);
  assign old_hit_b   = old_v   && (addr_q[head_q] == lk_addr_b);
  assign young_hit_b = young_v && (addr_q[yidx]   == lk_addr_b);

  assign lk_hit_a  = old_hit_a || young_hit_a;
  assign lk_hit_b  = old_hit_b || young_hit_b;
  assign lk_data_a = young_hit_a ? data_q[yidx] : (old_hit_a ? data_q[head_q] : '0);
  assign lk_data_b = young_hit_b ? data_q[yidx] : (old_hit_b ? data_q[head_q] : '0);

endmodule
